// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU; holds HI/LO for mfhi/mflo.
// Results are formed combinationally from latched operands; the down-counter models latency.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] md_input1,
  input  logic [31:0] md_input2,
  input  logic [2:0]  mdop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_op;
  logic [DW-1:0]   r_a, r_b, r_hi, r_lo;
  logic [DW-1:0]   w_hi_nxt, w_lo_nxt;
  logic            w_md_start, w_is_mul, w_latch, w_commit;
  logic [CW-1:0]   w_lat;
  logic [2:0]      w_op;
  logic [DW-1:0]   w_a, w_b;
  logic [2*DW-1:0] w_prod_s, w_prod_u;
  logic            w_sdiv, w_neg_a, w_neg_b;
  logic [DW-1:0]   w_mag_a, w_mag_b, w_div_b, w_q_u, w_r_u, w_quo, w_rem;

  assign w_md_start = start && (mdop >= OP_MULT) && (mdop <= OP_DIVU);
  assign w_is_mul   = (mdop == OP_MULT) || (mdop == OP_MULTU);
  assign w_lat      = w_is_mul ? MULT_LAT : DIV_LAT;

  // Live operands serve a single-cycle op issued from IDLE; latched ones otherwise
  assign w_op = (r_state == S_IDLE) ? mdop      : r_op;
  assign w_a  = (r_state == S_IDLE) ? md_input1 : r_a;
  assign w_b  = (r_state == S_IDLE) ? md_input2 : r_b;

  // Low 64 bits of sign-extended operands give the signed product
  assign w_prod_s = {{DW{w_a[DW-1]}}, w_a} * {{DW{w_b[DW-1]}}, w_b};
  assign w_prod_u = {{DW{1'b0}}, w_a} * {{DW{1'b0}}, w_b};

  // Signed divide via magnitudes; avoids the INT_MIN/-1 hazard and truncates toward zero
  assign w_sdiv  = (w_op == OP_DIV);
  assign w_neg_a = w_sdiv & w_a[DW-1];
  assign w_neg_b = w_sdiv & w_b[DW-1];
  assign w_mag_a = w_neg_a ? -w_a : w_a;
  assign w_mag_b = w_neg_b ? -w_b : w_b;
  assign w_div_b = (w_b == '0) ? DW'(1) : w_mag_b;
  assign w_q_u   = w_mag_a / w_div_b;
  assign w_r_u   = w_mag_a % w_div_b;
  assign w_quo   = (w_neg_a ^ w_neg_b) ? -w_q_u : w_q_u;
  assign w_rem   = w_neg_a ? -w_r_u : w_r_u;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_md_start && (w_lat != '0)) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_latch   = 1'b0;
    w_commit  = 1'b0;
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_md_start) begin
          w_latch   = 1'b1;
          w_cnt_nxt = w_lat;
          w_commit  = (w_lat == '0);
        end
      end
      S_RUN: begin
        w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
        w_commit  = (r_cnt == '0);
      end
      default: ;
    endcase
    if (w_commit) begin
      case (w_op)
        OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
        OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
        OP_DIV, OP_DIVU: begin
          if (w_b != '0) begin
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quo;
          end
        end
        default: ;
      endcase
    end else if ((r_state == S_IDLE) && start) begin
      if (mdop == OP_MTHI) w_hi_nxt = md_input1;
      if (mdop == OP_MTLO) w_lo_nxt = md_input1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      if (w_latch) begin
        r_op <= mdop;
        r_a  <= md_input1;
        r_b  <= md_input2;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table for arithmetic/latency, hand sequences for
// divide-by-zero, ignored restart, mthi/mtlo and asynchronous reset mid-operation.
module tb_mdu;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;
  localparam int NVEC = 10;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] md_input1, md_input2;
  logic [2:0]  mdop;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;
  vec_t vecs [NVEC];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_input1(md_input1), .md_input2(md_input2),
    .mdop(mdop), .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge, then release start
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdop = op; md_input1 = a; md_input2 = b; start = 1'b1;
    step();
    start = 1'b0; mdop = OP_NONE;
  endtask

  // Full multi-cycle op: busy and held HI/LO after edges T..T+N-1, result after T+N
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    n = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
    issue(op, a, b);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s busy@T+%0d", name, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s hold_hi@T+%0d", name, k), hi, m_hi);
      chk($sformatf("%s hold_lo@T+%0d", name, k), lo, m_lo);
      step();
    end
    m_hi = ehi;
    m_lo = elo;
    chk($sformatf("%s busy_done", name), {31'd0, busy}, 32'd0);
    chk($sformatf("%s hi", name), hi, m_hi);
    chk($sformatf("%s lo", name), lo, m_lo);
  endtask

  initial begin
    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4] = '{OP_MULT,  32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    reset = 1'b1; start = 1'b0; mdop = OP_NONE; md_input1 = '0; md_input2 = '0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // mthi/mtlo then divide by zero leaves HI/LO untouched
    issue(OP_MTHI, 32'h11, 32'h0);
    m_hi = 32'h11;
    chk("mthi busy", {31'd0, busy}, 32'd0);
    chk("mthi hi", hi, m_hi);
    issue(OP_MTLO, 32'h22, 32'h0);
    m_lo = 32'h22;
    chk("mtlo lo", lo, m_lo);
    chk("mtlo hi_kept", hi, m_hi);
    run_op("div0", OP_DIV, 32'h00000005, 32'h0, 32'h11, 32'h22);

    // none / reserved ops with start do nothing
    issue(OP_NONE, 32'hDEAD, 32'hBEEF);
    chk("op0 busy", {31'd0, busy}, 32'd0);
    chk("op0 hi", hi, m_hi);
    chk("op0 lo", lo, m_lo);
    issue(OP_RSVD, 32'hDEAD, 32'hBEEF);
    chk("op7 busy", {31'd0, busy}, 32'd0);
    chk("op7 hi", hi, m_hi);
    chk("op7 lo", lo, m_lo);

    // second start at T+3 and operand changes mid-flight are ignored
    issue(OP_DIV, 32'd100, 32'd7);
    step();
    step();
    mdop = OP_MULT; md_input1 = 32'd3; md_input2 = 32'd5; start = 1'b1;
    step();
    start = 1'b0; mdop = OP_MTHI; md_input1 = 32'hFFFF; md_input2 = 32'd0;
    for (int k = 4; k < 10; k++) step();
    chk("restart busy@T+9", {31'd0, busy}, 32'd1);
    chk("restart hold_hi@T+9", hi, m_hi);
    step();
    m_hi = 32'd2; m_lo = 32'd14;
    chk("restart busy@T+10", {31'd0, busy}, 32'd0);
    chk("restart hi", hi, m_hi);
    chk("restart lo", lo, m_lo);
    mdop = OP_NONE;

    issue(OP_MTHI, 32'hABCD, 32'h0);
    m_hi = 32'hABCD;
    chk("mthi_abcd busy", {31'd0, busy}, 32'd0);
    chk("mthi_abcd hi", hi, m_hi);
    chk("mthi_abcd lo", lo, m_lo);

    // async reset mid-mult clears immediately and suppresses write-back
    issue(OP_MULT, 32'd3, 32'd5);
    step();
    step();
    #3 reset = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst hi", hi, 32'd0);
    chk("arst lo", lo, 32'd0);
    #2 reset = 1'b0;
    step();
    step();
    step();
    step();
    chk("arst busy@T+6", {31'd0, busy}, 32'd0);
    chk("arst hi@T+6", hi, 32'd0);
    chk("arst lo@T+6", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
